// File: rtl/biassram_r_pkg.sv
// Shared widths and state encoding for the bias SRAM read path.
package biassram_r_pkg;
  localparam int ADDR_CNT_BITS  = 9;
  localparam int BIAS_SRAM_WLEN = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_READY = 2'd3;
endpackage

// File: rtl/count_yi_v3.sv
// Wrapping up-counter 0..final_number-1, advances on i_enable; 1-cycle update latency.
// No backpressure: i_enable is taken every cycle it is high.
module count_yi_v3 #(
  parameter int BITS_OF_END_NUMBER = 9,
  parameter int final_number       = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_enable,
  output logic [BITS_OF_END_NUMBER-1:0] o_cnt
);
  localparam logic [BITS_OF_END_NUMBER-1:0] LAST = BITS_OF_END_NUMBER'(final_number - 1);

  logic [BITS_OF_END_NUMBER-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (i_enable)
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/biassram_r.sv
// Serves one bias per channel from the bias SRAM; bias valid 3 cycles after start/bias_next.
// bias_next is the only backpressure: one fetch per request, requests outside READY are dropped.
module biassram_r
  import biassram_r_pkg::*;
#(
  parameter int BIAS_ST_LENGTH = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bias_rd1st_start,
  output logic                      bias_rd1st_busy,
  output logic                      bias_rd1st_done,
  input  logic                      bias_next,
  output logic                      cen_biasr_0,
  output logic                      wen_biasr_0,
  output logic [ADDR_CNT_BITS-1:0]  addr_biasr_0,
  input  logic [BIAS_SRAM_WLEN-1:0] dout_biasr_0,
  output logic [BIAS_SRAM_WLEN-1:0] bias_out,
  output logic                      bias_valid,
  output logic                      bias_layer_done
);
  localparam logic [ADDR_CNT_BITS-1:0] LAST_IDX = ADDR_CNT_BITS'(BIAS_ST_LENGTH - 1);

  logic [1:0]                r_state;
  logic                      r_first;
  logic [BIAS_SRAM_WLEN-1:0] r_bias_out;
  logic                      r_bias_valid;
  logic                      r_rd1st_done;
  logic                      r_layer_done;
  logic [ADDR_CNT_BITS-1:0]  w_idx;
  logic                      w_cnt_en;

  assign w_cnt_en = (r_state == ST_READY) & bias_next;

  count_yi_v3 #(
    .BITS_OF_END_NUMBER (ADDR_CNT_BITS),
    .final_number       (BIAS_ST_LENGTH)
  ) u_idx_cnt (
    .clk      (clk),
    .reset    (reset),
    .i_enable (w_cnt_en),
    .o_cnt    (w_idx)
  );

  // r_first marks the fetch of bias[0] so only it reports busy/done to the writer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_first      <= 1'b0;
      r_bias_out   <= '0;
      r_bias_valid <= 1'b0;
      r_rd1st_done <= 1'b0;
      r_layer_done <= 1'b0;
    end else begin
      r_rd1st_done <= 1'b0;
      r_layer_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bias_rd1st_start) begin
            r_state <= ST_FETCH;
            r_first <= 1'b1;
          end
        end
        ST_FETCH: r_state <= ST_WAIT;
        ST_WAIT: begin
          r_state      <= ST_READY;
          r_bias_out   <= dout_biasr_0;
          r_bias_valid <= 1'b1;
          r_rd1st_done <= r_first;
          r_first      <= 1'b0;
        end
        ST_READY: begin
          if (bias_next) begin
            r_bias_valid <= 1'b0;
            if (w_idx == LAST_IDX) begin
              r_layer_done <= 1'b1;
              r_state      <= ST_IDLE;
            end else begin
              r_state <= ST_FETCH;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cen_biasr_0     = ~(r_state == ST_FETCH);
  assign wen_biasr_0     = 1'b1;
  assign addr_biasr_0    = w_idx;
  assign bias_rd1st_busy = r_first & ((r_state == ST_FETCH) | (r_state == ST_WAIT));
  assign bias_rd1st_done = r_rd1st_done;
  assign bias_out        = r_bias_out;
  assign bias_valid      = r_bias_valid;
  assign bias_layer_done = r_layer_done;
endmodule
